// File: rtl/lut_sched_pkg.sv
// Shared types and constants for the time-multiplexed LUT layer scheduler.
package lut_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic CFG_SEL_TT   = 1'b0;
  localparam logic CFG_SEL_CONN = 1'b1;

endpackage

// File: rtl/lut_tt_ram.sv
// Truth-table store: one bit per (neuron, table entry), written synchronously,
// read combinationally so the scheduler can look up one neuron per cycle.
module lut_tt_ram #(
  parameter int NUM_NEURONS = 8,
  parameter int FANIN       = 5,
  localparam int NN_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int DEPTH      = 2 ** (NN_W + FANIN)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [NN_W-1:0]  wr_neuron,
  input  logic [FANIN-1:0] wr_addr,
  input  logic             wr_bit,
  input  logic [NN_W-1:0]  rd_neuron,
  input  logic [FANIN-1:0] rd_addr,
  output logic             rd_bit
);

  // Contents survive reset on purpose: tables are configuration, not state.
  logic r_mem [DEPTH];

  // Synchronous table write, addressed as {neuron, entry}
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[{wr_neuron, wr_addr}] <= wr_bit;
    end
  end

  assign rd_bit = r_mem[{rd_neuron, rd_addr}];

endmodule

// File: rtl/lut_layer_scheduler.sv
// Evaluates one LUT-network layer by stepping through its neurons one per cycle
// over a shared gather mux and truth-table lookup.
module lut_layer_scheduler
  import lut_sched_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int NUM_NEURONS = 8,
  parameter int FANIN       = 5,
  localparam int IDX_W      = $clog2(IN_WIDTH),
  localparam int NN_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_data,
  input  logic                   cfg_we,
  input  logic                   cfg_sel,
  input  logic [NN_W-1:0]        cfg_neuron,
  input  logic [FANIN-1:0]       cfg_addr,
  input  logic [IDX_W-1:0]       cfg_data,
  output logic                   cfg_err
);

  localparam int SLOT_W = (FANIN > 1) ? $clog2(FANIN) : 1;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [IN_WIDTH-1:0]      r_in;
  logic [NN_W-1:0]          r_n;
  logic [NUM_NEURONS-1:0]   r_out_data;
  logic                     r_cfg_err;
  logic [IDX_W-1:0]         r_conn [NUM_NEURONS][FANIN];

  logic                     w_last_neuron;
  logic                     w_neuron_ok;
  logic                     w_conn_ok;
  logic                     w_cfg_ok;
  logic                     w_tt_we;
  logic                     w_conn_we;
  logic [FANIN-1:0]         w_tt_addr;
  logic                     w_tt_bit;
  logic                     w_in_ready;
  logic                     w_out_valid;

  assign w_last_neuron = (r_n == NN_W'(NUM_NEURONS - 1));

  // Config writes are legal only in IDLE and only to existing neurons/slots/inputs.
  assign w_neuron_ok = (32'(cfg_neuron) < 32'(NUM_NEURONS));
  assign w_conn_ok   = (32'(cfg_addr) < 32'(FANIN)) && (32'(cfg_data) < 32'(IN_WIDTH));
  assign w_cfg_ok    = cfg_we && (r_state == S_IDLE) && w_neuron_ok &&
                       ((cfg_sel == CFG_SEL_TT) || w_conn_ok);
  assign w_tt_we     = w_cfg_ok && (cfg_sel == CFG_SEL_TT);
  assign w_conn_we   = w_cfg_ok && (cfg_sel == CFG_SEL_CONN);

  // Gather: slot k of the current neuron picks one latched input bit (slot 0 = LSB).
  generate
    for (genvar gi = 0; gi < FANIN; gi++) begin : g_gather
      assign w_tt_addr[gi] = r_in[r_conn[r_n][gi]];
    end
  endgenerate

  lut_tt_ram #(
    .NUM_NEURONS(NUM_NEURONS),
    .FANIN      (FANIN)
  ) u_tt_ram (
    .clk      (clk),
    .we       (w_tt_we),
    .wr_neuron(cfg_neuron),
    .wr_addr  (cfg_addr),
    .wr_bit   (cfg_data[0]),
    .rd_neuron(r_n),
    .rd_addr  (w_tt_addr),
    .rd_bit   (w_tt_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> EVAL (one cycle per neuron) -> DONE -> IDLE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)      w_state_next = S_EVAL;
      S_EVAL:  if (w_last_neuron) w_state_next = S_DONE;
      S_DONE:  if (out_ready)     w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready  = 1'b1;
      S_DONE:  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch input at handshake, write one result bit per EVAL cycle, flag bad cfg
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in       <= '0;
      r_n        <= '0;
      r_out_data <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (r_state == S_IDLE && in_valid) begin
        r_in <= in_data;
        r_n  <= '0;
      end else if (r_state == S_EVAL) begin
        r_out_data[r_n] <= w_tt_bit;
        r_n             <= r_n + 1'b1;
      end
    end
  end

  // Connection map is configuration and is deliberately left untouched by reset
  always_ff @(posedge clk) begin
    if (w_conn_we) begin
      r_conn[cfg_neuron][cfg_addr[SLOT_W-1:0]] <= cfg_data;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_out_data;
  assign cfg_err   = r_cfg_err;

endmodule
